// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back queue.
// Optional same-cycle bypass is enabled by RF_WB_QUEUE_BYPASS_EN.
package rf_wb_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_W    = 3;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic [REG_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wbq_entry_t;

    typedef enum logic {
        SRC_LD,
        SRC_ALU
    } src_e;

endpackage

// File: rtl/wbq_fifo.sv
// Circular entry store for the write-back queue.
// Accepts up to two ordered pushes and one pop per cycle.
module wbq_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 19,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    push_cnt,
    input  logic [W-1:0]  push0,
    input  logic [W-1:0]  push1,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [PW-1:0] tail_nxt;

    assign tail_nxt = tail_ptr + PW'(1);

    // Empty queue presents zero so the write port idles at a known value.
    assign head = (count != '0) ? mem[head_ptr] : '0;

    // Storage, pointers and occupancy; push0 always lands before push1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_cnt != 2'd0) begin
                mem[tail_ptr] <= push0;
            end
            if (push_cnt == 2'd2) begin
                mem[tail_nxt] <= push1;
            end
            tail_ptr <= tail_ptr + PW'(push_cnt);
            if (pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            count <= count + CW'(push_cnt) - CW'(pop);
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// Write-back queue between ALU/load producers and the register file port.
// Define RF_WB_QUEUE_BYPASS_EN for same-cycle bypass when the queue is empty.
module rf_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = rf_wb_pkg::DATA_W,
    parameter int REG_W  = rf_wb_pkg::REG_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [REG_W-1:0]        alu_reg,
    input  logic [DATA_W-1:0]       alu_data,
    output logic                    alu_ready,
    input  logic                    ld_valid,
    input  logic [REG_W-1:0]        ld_reg,
    input  logic [DATA_W-1:0]       ld_data,
    output logic                    ld_ready,
    input  logic                    drain_en,
    output logic [REG_W-1:0]        writeRegSel,
    output logic [DATA_W-1:0]       writeData,
    output logic                    writeEn,
    output logic [(1<<REG_W)-1:0]   pending,
    output logic                    err
);

    localparam int NREG = 1 << REG_W;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int EW   = REG_W + DATA_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] NEAR = CW'(DEPTH - 1);

    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic [EW-1:0]     push0;
    logic [EW-1:0]     push1;
    logic [1:0]        push_cnt;
    logic [REG_W-1:0]  head_sel;
    logic [DATA_W-1:0] head_data;
    logic              empty;
    logic              pop;
    logic              ld_push;
    logic              alu_push;
    logic              byp_ld;
    logic              byp_alu;
    logic              x_err;
    logic              under;
    logic [NREG-1:0]   hit_ld;
    logic [NREG-1:0]   hit_alu;
    logic [NREG-1:0]   hit_pop;
    logic [CW-1:0]     cnt      [NREG];
    logic [CW-1:0]     cnt_next [NREG];

    rf_wb_pkg::src_e   first_src;

    assign empty = (count == '0);
    assign {head_sel, head_data} = head;
    assign pop = drain_en && !empty;

    // Readiness looks at registered occupancy only; a pop gives no credit.
    assign ld_ready  = (count < FULL);
    assign alu_ready = (count < NEAR) || ((count == NEAR) && !ld_valid);

`ifdef RF_WB_QUEUE_BYPASS_EN
    assign byp_ld  = !rst && empty && drain_en && ld_valid;
    assign byp_alu = !rst && empty && drain_en && !ld_valid && alu_valid;
`else
    assign byp_ld  = 1'b0;
    assign byp_alu = 1'b0;
`endif

    assign ld_push  = ld_valid && ld_ready && !byp_ld;
    assign alu_push = alu_valid && alu_ready && !byp_alu;
    assign push_cnt = {1'b0, ld_push} + {1'b0, alu_push};

    // Load wins the first slot; the ALU entry follows it when both push.
    assign first_src = ld_push ? rf_wb_pkg::SRC_LD : rf_wb_pkg::SRC_ALU;
    assign push0 = (first_src == rf_wb_pkg::SRC_LD) ?
                   {ld_reg, ld_data} : {alu_reg, alu_data};
    assign push1 = {alu_reg, alu_data};

    wbq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_cnt (push_cnt),
        .push0    (push0),
        .push1    (push1),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    // Register file port: head entry, overridden by a bypassed request.
    always_comb begin
        writeEn     = pop;
        writeRegSel = head_sel;
        writeData   = head_data;
        if (byp_ld) begin
            writeEn     = 1'b1;
            writeRegSel = ld_reg;
            writeData   = ld_data;
        end else if (byp_alu) begin
            writeEn     = 1'b1;
            writeRegSel = alu_reg;
            writeData   = alu_data;
        end
    end

    // Per-register decode of this cycle's enqueues and the pop.
    always_comb begin
        hit_ld  = '0;
        hit_alu = '0;
        hit_pop = '0;
        for (int r = 0; r < NREG; r++) begin
            hit_ld[r]  = ld_push  && (ld_reg   == REG_W'(r));
            hit_alu[r] = alu_push && (alu_reg  == REG_W'(r));
            hit_pop[r] = pop      && (head_sel == REG_W'(r));
        end
    end

    // Net scoreboard update and underflow detection.
    always_comb begin
        under = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_next[r] = cnt[r] + CW'(hit_ld[r]) + CW'(hit_alu[r])
                        - CW'(hit_pop[r]);
            if (hit_pop[r] && (cnt[r] == '0) && !hit_ld[r] && !hit_alu[r]) begin
                under = 1'b1;
            end
        end
    end

    assign x_err = (alu_valid && $isunknown(alu_reg)) ||
                   (ld_valid  && $isunknown(ld_reg));

    // Scoreboard counters, registered pending flags and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            pending <= '0;
            err     <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r]     <= cnt_next[r];
                pending[r] <= (cnt_next[r] != '0);
            end
            err <= err || x_err || under;
        end
    end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed self-checking bench for rf_wb_queue (DEPTH=4, 16-bit, 8 regs).
// Bypass expectations follow RF_WB_QUEUE_BYPASS_EN.
module tb_rf_wb_queue;
    import rf_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [2:0]  alu_reg;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [2:0]  ld_reg;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        drain_en;
    logic [2:0]  writeRegSel;
    logic [15:0] writeData;
    logic        writeEn;
    logic [7:0]  pending;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] port;
    logic [19:0] exp_port;
    logic [7:0]  exp_pend;

    assign port = {writeEn, writeRegSel, writeData};

    always #5 clk = ~clk;

    rf_wb_queue #(
        .DEPTH  (4),
        .DATA_W (16),
        .REG_W  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .ld_valid    (ld_valid),
        .ld_reg      (ld_reg),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .drain_en    (drain_en),
        .writeRegSel (writeRegSel),
        .writeData   (writeData),
        .writeEn     (writeEn),
        .pending     (pending),
        .err         (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_reg   = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_reg    = '0;
        ld_data   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drain_en = 1'b0;
        idle();
        step();
        step();
        n_checks++;
        if (port !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_port got %h want 00000", port);
        end
        n_checks++;
        if (pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_pending got %h want 00", pending);
        end
        n_checks++;
        if ({alu_ready, ld_ready, err} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 110", {alu_ready, ld_ready, err});
        end
        drain_en = 1'b1;
        #1;
        n_checks++;
        if (writeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drain_wen got %b want 0", writeEn);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain_en = 1'b0;
        step();
        n_checks++;
        if ({port, pending} !== 28'h0) begin
            n_fail++;
            $display("FAIL post_reset got %h_%h want 0", port, pending);
        end
    endtask

    task automatic test_single();
        drain_en  = 1'b1;
        alu_valid = 1'b1;
        alu_reg   = 3'd3;
        alu_data  = 16'h1234;
        #1;
        n_checks++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready got %b want 1", alu_ready);
        end
`ifdef RF_WB_QUEUE_BYPASS_EN
        exp_port = {1'b1, 3'd3, 16'h1234};
`else
        exp_port = 20'h0;
`endif
        n_checks++;
        if (port !== exp_port) begin
            n_fail++;
            $display("FAIL single_c0 got %h want %h", port, exp_port);
        end
        step();
        idle();
        #1;
`ifdef RF_WB_QUEUE_BYPASS_EN
        exp_port = 20'h0;
        exp_pend = 8'h00;
`else
        exp_port = {1'b1, 3'd3, 16'h1234};
        exp_pend = 8'h08;
`endif
        n_checks++;
        if (port !== exp_port) begin
            n_fail++;
            $display("FAIL single_c1 got %h want %h", port, exp_port);
        end
        n_checks++;
        if (pending !== exp_pend) begin
            n_fail++;
            $display("FAIL single_pend1 got %h want %h", pending, exp_pend);
        end
        step();
        n_checks++;
        if ({port, pending} !== 28'h0) begin
            n_fail++;
            $display("FAIL single_c2 got %h_%h want 0", port, pending);
        end
        drain_en = 1'b0;
    endtask

    task automatic test_dual();
        drain_en  = 1'b0;
        ld_valid  = 1'b1;
        ld_reg    = 3'd1;
        ld_data   = 16'hAAAA;
        alu_valid = 1'b1;
        alu_reg   = 3'd2;
        alu_data  = 16'h5555;
        #1;
        n_checks++;
        if ({ld_ready, alu_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL dual_ready got %b want 11", {ld_ready, alu_ready});
        end
        step();
        idle();
        #1;
        n_checks++;
        if (pending !== 8'h06) begin
            n_fail++;
            $display("FAIL dual_pend got %h want 06", pending);
        end
        n_checks++;
        if (port !== {1'b0, 3'd1, 16'hAAAA}) begin
            n_fail++;
            $display("FAIL dual_hold got %h want 1aaaa", port);
        end
        drain_en = 1'b1;
        #1;
        n_checks++;
        if (port !== {1'b1, 3'd1, 16'hAAAA}) begin
            n_fail++;
            $display("FAIL dual_first got %h want 9aaaa", port);
        end
        step();
        n_checks++;
        if ({port, pending} !== {1'b1, 3'd2, 16'h5555, 8'h04}) begin
            n_fail++;
            $display("FAIL dual_second got %h_%h want a5555_04", port, pending);
        end
        step();
        n_checks++;
        if ({port, pending} !== 28'h0) begin
            n_fail++;
            $display("FAIL dual_done got %h_%h want 0", port, pending);
        end
        drain_en = 1'b0;
    endtask

    task automatic test_full();
        wbq_entry_t exp_q [4];
        exp_q[0] = '{sel: 3'd1, data: 16'h0101};
        exp_q[1] = '{sel: 3'd2, data: 16'h0102};
        exp_q[2] = '{sel: 3'd3, data: 16'h0103};
        exp_q[3] = '{sel: 3'd4, data: 16'h0104};
        drain_en  = 1'b0;
        ld_valid  = 1'b1;
        ld_reg    = 3'd0;
        ld_data   = 16'h0100;
        alu_valid = 1'b1;
        alu_reg   = 3'd1;
        alu_data  = 16'h0101;
        step();
        alu_valid = 1'b0;
        ld_reg    = 3'd2;
        ld_data   = 16'h0102;
        step();
        ld_reg    = 3'd3;
        ld_data   = 16'h0103;
        alu_valid = 1'b1;
        alu_reg   = 3'd4;
        alu_data  = 16'h0104;
        #1;
        n_checks++;
        if ({ld_ready, alu_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_c3_ready got %b want 10", {ld_ready, alu_ready});
        end
        step();
        ld_valid = 1'b0;
        #1;
        n_checks++;
        if ({ld_ready, alu_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_c4_ready got %b want 00", {ld_ready, alu_ready});
        end
        n_checks++;
        if ({writeEn, pending} !== {1'b0, 8'h0F}) begin
            n_fail++;
            $display("FAIL full_c4_pend got %b_%h want 0_0f", writeEn, pending);
        end
        drain_en = 1'b1;
        #1;
        n_checks++;
        if ({port, alu_ready} !== {1'b1, 3'd0, 16'h0100, 1'b0}) begin
            n_fail++;
            $display("FAIL full_pop_nocredit got %h_%b want 80100_0", port, alu_ready);
        end
        step();
        drain_en = 1'b0;
        #1;
        n_checks++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_alu_retry got %b want 1", alu_ready);
        end
        step();
        idle();
        #1;
        n_checks++;
        if ({pending, ld_ready} !== {8'h1E, 1'b0}) begin
            n_fail++;
            $display("FAIL full_refill got %h_%b want 1e_0", pending, ld_ready);
        end
        drain_en = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (port !== {1'b1, exp_q[i].sel, exp_q[i].data}) begin
                n_fail++;
                $display("FAIL full_drain%0d got %h want %h", i, port,
                         {1'b1, exp_q[i].sel, exp_q[i].data});
            end
            step();
        end
        n_checks++;
        if ({writeEn, pending} !== 9'h0) begin
            n_fail++;
            $display("FAIL full_empty got %b_%h want 0_00", writeEn, pending);
        end
        drain_en = 1'b0;
    endtask

    task automatic test_same_reg();
        drain_en  = 1'b0;
        alu_valid = 1'b1;
        alu_reg   = 3'd5;
        alu_data  = 16'h0001;
        step();
        alu_data  = 16'h0002;
        step();
        idle();
        #1;
        n_checks++;
        if (pending !== 8'h20) begin
            n_fail++;
            $display("FAIL same_pend2 got %h want 20", pending);
        end
        drain_en = 1'b1;
        #1;
        n_checks++;
        if (port !== {1'b1, 3'd5, 16'h0001}) begin
            n_fail++;
            $display("FAIL same_first got %h want d0001", port);
        end
        step();
        n_checks++;
        if ({port, pending} !== {1'b1, 3'd5, 16'h0002, 8'h20}) begin
            n_fail++;
            $display("FAIL same_second got %h_%h want d0002_20", port, pending);
        end
        step();
        n_checks++;
        if ({writeEn, pending} !== 9'h0) begin
            n_fail++;
            $display("FAIL same_done got %b_%h want 0_00", writeEn, pending);
        end
        drain_en  = 1'b0;
        ld_valid  = 1'b1;
        ld_reg    = 3'd6;
        ld_data   = 16'h0006;
        alu_valid = 1'b1;
        alu_reg   = 3'd6;
        alu_data  = 16'h0007;
        step();
        idle();
        drain_en = 1'b1;
        #1;
        n_checks++;
        if ({port, pending} !== {1'b1, 3'd6, 16'h0006, 8'h40}) begin
            n_fail++;
            $display("FAIL same_dual1 got %h_%h want e0006_40", port, pending);
        end
        step();
        n_checks++;
        if ({port, pending} !== {1'b1, 3'd6, 16'h0007, 8'h40}) begin
            n_fail++;
            $display("FAIL same_dual2 got %h_%h want e0007_40", port, pending);
        end
        step();
        n_checks++;
        if (pending !== 8'h00) begin
            n_fail++;
            $display("FAIL same_dual_done got %h want 00", pending);
        end
        drain_en = 1'b0;
    endtask

    task automatic test_async_reset();
        drain_en  = 1'b0;
        ld_valid  = 1'b1;
        ld_reg    = 3'd1;
        ld_data   = 16'h0AAA;
        alu_valid = 1'b1;
        alu_reg   = 3'd2;
        alu_data  = 16'h0BBB;
        step();
        alu_valid = 1'b0;
        ld_reg    = 3'd3;
        ld_data   = 16'h0CCC;
        step();
        idle();
        drain_en = 1'b1;
        #1;
        n_checks++;
        if ({port, pending} !== {1'b1, 3'd1, 16'h0AAA, 8'h0E}) begin
            n_fail++;
            $display("FAIL arst_pre got %h_%h want 90aaa_0e", port, pending);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({port, pending} !== 28'h0) begin
            n_fail++;
            $display("FAIL arst_immediate got %h_%h want 0", port, pending);
        end
        n_checks++;
        if ({ld_ready, alu_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL arst_ready got %b want 11", {ld_ready, alu_ready});
        end
        step();
        n_checks++;
        if (writeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_hold got %b want 0", writeEn);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({writeEn, pending} !== 9'h0) begin
                n_fail++;
                $display("FAIL arst_after%0d got %b_%h want 0_00", i, writeEn, pending);
            end
            step();
        end
        drain_en = 1'b0;
    endtask

`ifdef RF_WB_QUEUE_BYPASS_EN
    task automatic test_bypass();
        drain_en = 1'b1;
        ld_valid = 1'b1;
        ld_reg   = 3'd7;
        ld_data  = 16'hBEEF;
        #1;
        n_checks++;
        if ({port, ld_ready} !== {1'b1, 3'd7, 16'hBEEF, 1'b1}) begin
            n_fail++;
            $display("FAIL byp_ld got %h_%b want fbeef_1", port, ld_ready);
        end
        step();
        idle();
        #1;
        n_checks++;
        if ({writeEn, pending} !== 9'h0) begin
            n_fail++;
            $display("FAIL byp_ld_after got %b_%h want 0_00", writeEn, pending);
        end
        ld_valid  = 1'b1;
        ld_reg    = 3'd6;
        ld_data   = 16'h1111;
        alu_valid = 1'b1;
        alu_reg   = 3'd2;
        alu_data  = 16'h2222;
        #1;
        n_checks++;
        if (port !== {1'b1, 3'd6, 16'h1111}) begin
            n_fail++;
            $display("FAIL byp_both got %h want e1111", port);
        end
        step();
        idle();
        #1;
        n_checks++;
        if ({port, pending} !== {1'b1, 3'd2, 16'h2222, 8'h04}) begin
            n_fail++;
            $display("FAIL byp_alu_queued got %h_%h want a2222_04", port, pending);
        end
        step();
        n_checks++;
        if ({writeEn, pending} !== 9'h0) begin
            n_fail++;
            $display("FAIL byp_done got %b_%h want 0_00", writeEn, pending);
        end
        drain_en = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_full();
        test_same_reg();
        test_async_reset();
`ifdef RF_WB_QUEUE_BYPASS_EN
        test_bypass();
`endif
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_flag got %b want 0", err);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
